// File: rtl/led_fader.sv
// led_fader: eight LEDs fade toward the latest accepted on/off pattern, with a shared 15-cycle PWM.
// Build option: define LED_FADER_GAMMA_EN to map each brightness level through a perceptual gamma table.
module led_fader #(
  parameter int RAMP_DIV = 1024
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in_pattern,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] led_out
);

  typedef enum logic {IDLE, RAMP} state_t;

  localparam logic [15:0] DIV_LAST = 16'(RAMP_DIV - 1);

  state_t      state_q;
  logic        ready_q;
  logic [7:0]  target_q;
  logic [15:0] div_cnt_q;
  logic [3:0]  pwm_cnt_q;
  logic [7:0]  led_q;
  logic [3:0]  level_q [8];
  logic [3:0]  level_d [8];
  logic [3:0]  duty    [8];
  logic [7:0]  done_after_step;
  logic [7:0]  done_for_new;
  logic        accept;
  logic        step;

`ifdef LED_FADER_GAMMA_EN
  function automatic logic [3:0] gamma(input logic [3:0] lv);
    logic [3:0] g;
    case (lv)
      4'd0, 4'd1, 4'd2: g = 4'd0;
      4'd3, 4'd4, 4'd5: g = 4'd1;
      4'd6, 4'd7:       g = 4'd2;
      4'd8:             g = 4'd3;
      4'd9:             g = 4'd4;
      4'd10:            g = 4'd5;
      4'd11:            g = 4'd6;
      4'd12:            g = 4'd8;
      4'd13:            g = 4'd10;
      4'd14:            g = 4'd12;
      default:          g = 4'd15;
    endcase
    return g;
  endfunction
`endif

  assign accept = in_valid && ready_q;
  assign step   = (state_q == RAMP) && (div_cnt_q == DIV_LAST);

  // Per-LED saturating step toward the target endpoint, plus endpoint detection.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_led
      always_comb begin
        level_d[gi] = level_q[gi];
        if (target_q[gi] && level_q[gi] != 4'd15) begin
          level_d[gi] = level_q[gi] + 4'd1;
        end else if (!target_q[gi] && level_q[gi] != 4'd0) begin
          level_d[gi] = level_q[gi] - 4'd1;
        end
      end

      assign done_after_step[gi] = (level_d[gi] == (target_q[gi] ? 4'd15 : 4'd0));
      assign done_for_new[gi]    = (level_q[gi] == (in_pattern[gi] ? 4'd15 : 4'd0));

`ifdef LED_FADER_GAMMA_EN
      assign duty[gi] = gamma(level_q[gi]);
`else
      assign duty[gi] = level_q[gi];
`endif
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ready_q   <= 1'b1;
      target_q  <= '0;
      div_cnt_q <= '0;
      pwm_cnt_q <= '0;
      led_q     <= '0;
      for (int i = 0; i < 8; i++) level_q[i] <= '0;
    end else begin
      pwm_cnt_q <= (pwm_cnt_q == 4'd14) ? 4'd0 : pwm_cnt_q + 4'd1;
      for (int i = 0; i < 8; i++) led_q[i] <= (pwm_cnt_q < duty[i]);

      case (state_q)
        IDLE: begin
          if (accept) begin
            target_q  <= in_pattern;
            div_cnt_q <= '0;
            // A pattern matching the current endpoints leaves the block ready.
            if (done_for_new != 8'hFF) begin
              state_q <= RAMP;
              ready_q <= 1'b0;
            end
          end
        end
        RAMP: begin
          if (step) begin
            div_cnt_q <= '0;
            for (int i = 0; i < 8; i++) level_q[i] <= level_d[i];
            if (&done_after_step) begin
              state_q <= IDLE;
              ready_q <= 1'b1;
            end
          end else begin
            div_cnt_q <= div_cnt_q + 16'd1;
          end
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready = ready_q;
  assign led_out  = led_q;

endmodule

// File: tb/tb_led_fader.sv
// Bench for led_fader: time-based fade model, vector table, directed corner sequences, random traffic.
// Honours LED_FADER_GAMMA_EN to pick the expected duty mapping.
module tb_led_fader;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] in_pattern = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] led_out;

  led_fader #(.RAMP_DIV(D)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_pattern(in_pattern),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .led_out   (led_out)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: levels are a closed-form function of cycles elapsed since the last accept.
  int         cyc;
  int         acc_cyc;
  int         start_lv [8];
  logic [7:0] tgt;
  logic [7:0] exp_led;

`ifdef LED_FADER_GAMMA_EN
  int gtab [16] = '{0, 0, 0, 1, 1, 1, 2, 2, 3, 4, 5, 6, 8, 10, 12, 15};
  function automatic int duty_of(int l);
    return gtab[l];
  endfunction
`else
  function automatic int duty_of(int l);
    return l;
  endfunction
`endif

  function automatic int m_level(int i, int n);
    int k;
    if (n <= acc_cyc) return start_lv[i];
    k = (n - acc_cyc - 1) / D;
    if (tgt[i]) return (start_lv[i] + k > 15) ? 15 : start_lv[i] + k;
    return (start_lv[i] - k < 0) ? 0 : start_lv[i] - k;
  endfunction

  function automatic logic m_ready(int n);
    for (int i = 0; i < 8; i++)
      if (m_level(i, n) != (tgt[i] ? 15 : 0)) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    cyc = 0;
    acc_cyc = 0;
    tgt = 8'h00;
    exp_led = 8'h00;
    for (int i = 0; i < 8; i++) start_lv[i] = 0;
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  // Called at a falling edge with inputs already set for the current cycle.
  task automatic tick();
    logic [7:0] nxt;
    check("led_out", led_out, exp_led);
    check("in_ready", {7'd0, in_ready}, {7'd0, m_ready(cyc)});
    nxt = 8'h00;
    for (int i = 0; i < 8; i++) nxt[i] = ((cyc % 15) < duty_of(m_level(i, cyc)));
    if (in_valid && m_ready(cyc)) begin
      for (int i = 0; i < 8; i++) start_lv[i] = m_level(i, cyc);
      tgt = in_pattern;
      acc_cyc = cyc;
    end
    @(posedge clk);
    @(negedge clk);
    exp_led = nxt;
    cyc++;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) begin
      in_valid = 1'b0;
      in_pattern = 8'($urandom);
      tick();
    end
  endtask

  task automatic offer(input logic [7:0] pat);
    int guard;
    guard = 0;
    while (!m_ready(cyc) && guard < 200) begin
      run(1);
      guard++;
    end
    if (guard >= 200) begin
      n_cmp++;
      n_bad++;
      $display("FAIL ready_timeout at cycle %0d: got in_ready=%0b, expected 1", cyc, in_ready);
    end
    $display("cycle %0d: offer pattern %h", cyc, pat);
    in_pattern = pat;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic pulse_reset(input int hold);
    rst_n = 1'b0;
    #1;
    check("reset_led", led_out, 8'h00);
    check("reset_ready", {7'd0, in_ready}, 8'h01);
    for (int k = 0; k < hold; k++) begin
      in_valid = 1'($urandom);
      in_pattern = 8'($urandom);
      @(negedge clk);
      check("reset_hold_led", led_out, 8'h00);
      check("reset_hold_ready", {7'd0, in_ready}, 8'h01);
    end
    in_valid = 1'b0;
    rst_n = 1'b1;
    model_reset();
    $display("reset released");
  endtask

  typedef struct {
    logic [7:0] pat;
    int         wait_c;
    logic [7:0] exp_led;
    logic       exp_rdy;
  } vec_t;

  vec_t tbl [7];

  initial begin
    int cnt_dut;
    int cnt_mod;

    tbl[0] = '{pat: 8'hF0, wait_c: 70, exp_led: 8'hF0, exp_rdy: 1'b1};
    tbl[1] = '{pat: 8'hF0, wait_c: 2,  exp_led: 8'hF0, exp_rdy: 1'b1};
    tbl[2] = '{pat: 8'h00, wait_c: 1,  exp_led: 8'hF0, exp_rdy: 1'b0};
    tbl[3] = '{pat: 8'hA5, wait_c: 70, exp_led: 8'hA5, exp_rdy: 1'b1};
    tbl[4] = '{pat: 8'hA5, wait_c: 1,  exp_led: 8'hA5, exp_rdy: 1'b1};
    tbl[5] = '{pat: 8'h5A, wait_c: 1,  exp_led: 8'hA5, exp_rdy: 1'b0};
    tbl[6] = '{pat: 8'h00, wait_c: 70, exp_led: 8'h00, exp_rdy: 1'b1};

    model_reset();
    @(negedge clk);
    pulse_reset(5);
    run(30);

    // Fade up from all-off.
    offer(8'hFF);
    check("fadeup_busy_c1", {7'd0, in_ready}, 8'h00);
    run(59);
    check("fadeup_busy_c60", {7'd0, in_ready}, 8'h00);
    run(1);
    check("fadeup_ready_c61", {7'd0, in_ready}, 8'h01);
    for (int k = 0; k < 30; k++) begin
      check("fadeup_steady", led_out, 8'hFF);
      run(1);
    end

    // Mixed fade from all-on.
    offer(8'h0F);
    run(59);
    check("mixed_busy_c60", {7'd0, in_ready}, 8'h00);
    run(1);
    check("mixed_ready_c61", {7'd0, in_ready}, 8'h01);
    run(2);
    for (int k = 0; k < 15; k++) begin
      check("mixed_steady", led_out, 8'h0F);
      run(1);
    end

    foreach (tbl[v]) begin
      offer(tbl[v].pat);
      run(tbl[v].wait_c - 1);
      $display("vector %0d: pattern %h led_out=%h in_ready=%0b", v, tbl[v].pat, led_out, in_ready);
      check("vec_led", led_out, tbl[v].exp_led);
      check("vec_ready", {7'd0, in_ready}, {7'd0, tbl[v].exp_rdy});
    end

    // Mid-ramp duty window on LED 0.
    offer(8'h01);
    run(32);
    cnt_dut = 0;
    cnt_mod = 0;
    for (int k = 0; k < 15; k++) begin
      cnt_dut += int'(led_out[0]);
      cnt_mod += int'(exp_led[0]);
      check("midramp_upper_bits", led_out & 8'hFE, 8'h00);
      run(1);
    end
    $display("mid-ramp window: led0 high %0d of 15 cycles", cnt_dut);
    check("midramp_high_count", 8'(cnt_dut), 8'(cnt_mod));

    // Busy pulse is ignored, then a no-op accept keeps ready high.
    offer(8'hFF);
    run(10);
    in_pattern = 8'h00;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    run(60);
    check("busy_ignored_led", led_out, 8'hFF);
    offer(8'hFF);
    for (int k = 0; k < 5; k++) begin
      check("noop_ready", {7'd0, in_ready}, 8'h01);
      run(1);
    end

    // Reset in the middle of a fade, then a full fresh fade.
    offer(8'h00);
    run(61);
    offer(8'hFF);
    run(28);
    pulse_reset(1);
    offer(8'hFF);
    run(59);
    check("postreset_busy_c60", {7'd0, in_ready}, 8'h00);
    run(1);
    check("postreset_ready_c61", {7'd0, in_ready}, 8'h01);

    // Random traffic against the model.
    for (int k = 0; k < 1500; k++) begin
      in_valid = ($urandom_range(0, 7) == 0);
      in_pattern = 8'($urandom);
      if (in_valid && m_ready(cyc)) $display("cycle %0d: random accept %h", cyc, in_pattern);
      tick();
    end
    in_valid = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/led_fader.md
# led_fader

Downstream consumer of the 8-bit LFSR pattern. Each of the 8 LED outputs fades smoothly toward the on/off state commanded by the latest accepted pattern, instead of switching hard. Every LED uses a 4-bit brightness level, stepped once per `RAMP_DIV` clocks and rendered by a shared 15-cycle PWM. The block sits between the pattern generator and `uo_out`, with a valid/ready handshake on the pattern side.

## Interface
- `RAMP_DIV`, default 1024: clock cycles per brightness step. Legal range is 2..65535.
- `clk` input 1: system clock. One clock domain.
- `rst_n` input 1: asynchronous, active-low reset.
- `in_pattern` input 8: target pattern; bit i = 1 means LED i on.
- `in_valid` input 1: pattern offered this cycle.
- `in_ready` output 1: block can accept a pattern. High only in IDLE.
- `led_out` output 8: registered PWM drive, one bit per LED.

## Operation
- Registers:
  - `level[i]`, 4 bits, one per LED.
  - `target[i]`, 1 bit per LED.
  - `div_cnt`: step prescaler.
  - `pwm_cnt`, 4 bits, counts 0..14 and wraps.
  - `state` ∈ {IDLE, RAMP}.
- Accept rule: a pattern is taken when `in_valid && in_ready`, and `target <= in_pattern`.
  - `in_valid` while `in_ready` = 0 is ignored.
  - Nothing is queued; the upstream stage must hold or drop the pattern.
- IDLE → RAMP: on accept, if any `level[i]` ≠ (`target_new[i]` ? 15 : 0). Otherwise stay in IDLE.
- On accept, `div_cnt` clears to 0.
- RAMP:
  - `div_cnt` increments every cycle.
  - When `div_cnt` = `RAMP_DIV`−1, a step occurs and `div_cnt` wraps to 0.
  - On a step, each `level[i]` moves one count toward 15 (target 1) or 0 (target 0).
  - Levels already at their endpoint hold; they saturate and never wrap.
- RAMP → IDLE: on the step where every level reaches its endpoint.
- PWM:
  - `pwm_cnt` free-runs in both states.
  - `led_out[i]` <= (`pwm_cnt` < `duty[i]`).
  - `duty[i]` = `level[i]` (see Configuration).
  - Duty 0 gives constant 0; duty 15 gives constant 1, since `pwm_cnt` never reaches 15.
- Arithmetic is unsigned. The step compare uses 16-bit `div_cnt`.

## Timing
- Reset values: all `level` = 0, `target` = 0, `div_cnt` = 0, `pwm_cnt` = 0, `state` = IDLE, `led_out` = 8'h00, `in_ready` = 1.
- Asserting `rst_n` low at any time, including mid-ramp, clears everything immediately and asynchronously. There is no partial-fade retention.
- Accept at cycle 0:
  - `in_ready` = 0 from cycle 1 (only if a ramp is required).
  - First step lands at the clock edge ending cycle `RAMP_DIV`.
- Step k occurs at cycle k·`RAMP_DIV`. A full 0↔15 fade takes 15·`RAMP_DIV` cycles.
- `in_ready` returns to 1 in the cycle after the final step.
- `led_out` lags the `pwm_cnt`/`level` compare by one register stage.
- PWM period is exactly 15 cycles, independent of `RAMP_DIV`.
- Mixed patterns: LEDs ramping up and LEDs ramping down step simultaneously. Completion waits on the slowest LED.
- An accept of a pattern equal to the current endpoints keeps `in_ready` = 1 continuously.

## Configuration
- `LED_FADER_GAMMA_EN` defined:
  - `duty[i]` = gamma(`level[i]`).
  - The table for levels 0..15 is 0,0,0,1,1,1,2,2,3,4,5,6,8,10,12,15.
  - This gives a perceptually linear fade. Endpoints (0 → 0, 15 → 15) are unchanged, so steady-state on/off behaviour is identical.
- `LED_FADER_GAMMA_EN` not defined: `duty[i]` = `level[i]` (linear).
- Handshake and ramp timing are identical in both builds.

## Test plan
All scenarios use `RAMP_DIV` = 4.
- **Reset:** hold `rst_n` = 0 with random `in_*` → `led_out` = 00, `in_ready` = 1. Release → `led_out` stays 00 for ≥30 cycles.
- **Fade up:** accept FF at cycle 0 → `in_ready` = 0 at cycle 1; step 15 at cycle 60; `in_ready` = 1 at cycle 61. `led_out` = FF constant over the next 30 cycles.
- **Mid-ramp duty:** accept 01, then sample one full 15-cycle window after step 8 (cycles 33..47):
  - Linear build: `led_out[0]` high 8/15 cycles.
  - Gamma build: high 3/15 cycles.
  - Bits 7..1 stay 0 in both builds.
- **Mixed fade:** from all-on, accept 0F → bits 3..0 stay 1, bits 7..4 fall to 0 after step 15, `in_ready` returns after 60 cycles.
- **Busy/no-op:** pulse `in_valid` with 00 during a ramp → ignored, ramp completes toward the old target. Then, in IDLE, accept the current pattern → `in_ready` never drops.
- **Reset mid-ramp:** at step 7 of an FF fade, pulse `rst_n` low for 1 cycle → `led_out` = 00 and `in_ready` = 1 immediately. A new FF accept then takes a full 60 cycles.
